// File: rtl/wgt_pkg.sv
// Shared constants and drain-state encoding for the weight tile loader.
package wgt_pkg;

    localparam int unsigned ARRAY_N = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ROW_W   = ARRAY_N * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SWAP  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/wgt_tile_bank.sv
// One tile of weight rows: ARRAY_N x ROW_W register file, one write port, one async read port.
module wgt_tile_bank #(
    parameter int unsigned ARRAY_N = 16,
    parameter int unsigned ROW_W   = 128,
    parameter int unsigned AW      = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ROW_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [ROW_W-1:0] rdata_o
);

    logic [ROW_W-1:0] mem_q [ARRAY_N];

    // Contents are qualified by the loader's full flags, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wgt_tile_loader.sv
// Captures returning weight rows into a ping-pong pair of tile banks and drains each
// complete tile into the systolic array shift chain, followed by a one-cycle swap pulse.
module wgt_tile_loader #(
    parameter int unsigned ARRAY_N = wgt_pkg::ARRAY_N,
    parameter int unsigned DATA_W  = wgt_pkg::DATA_W,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rd_req,
    input  logic [ARRAY_N*DATA_W-1:0] rd_data,
    output logic                      wgt_ready,
    input  logic                      array_wgt_req,
    output logic                      wgt_shift_en,
    output logic [ARRAY_N*DATA_W-1:0] wgt_shift_data,
    output logic                      wgt_swap,
    output logic                      ovf_err
);

    import wgt_pkg::*;

    localparam int unsigned       ROW_BITS = ARRAY_N * DATA_W;
    localparam int unsigned       AW       = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(ARRAY_N - 1);

    logic [RD_LAT-1:0]   dly_q;
    logic                rd_vld;

    logic [CNT_W-1:0]    wr_row_q, wr_row_d;
    logic                wr_sel_q, wr_sel_d;
    logic [1:0]          full_q, full_d, full_set, full_clr;
    logic                ovf_q, ovf_d;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;

    drain_state_e        state_q, state_d;
    logic [CNT_W-1:0]    rd_row_q, rd_row_d;
    logic                rd_sel_q, rd_sel_d;
    logic                shift_en_q, shift_en_d;
    logic [ROW_BITS-1:0] shift_data_q, shift_data_d;
    logic                swap_q, swap_d;
    logic [AW-1:0]       rd_addr;
    logic [ROW_BITS-1:0] bank0_rdata, bank1_rdata, rd_row_data;

    assign rd_vld = dly_q[RD_LAT-1];

    wgt_tile_bank #(
        .ARRAY_N (ARRAY_N),
        .ROW_W   (ROW_BITS),
        .AW      (AW)
    ) u_bank0 (
        .clk     (clk),
        .we_i    (wr_en && !wr_sel_q),
        .waddr_i (wr_addr),
        .wdata_i (rd_data),
        .raddr_i (rd_addr),
        .rdata_o (bank0_rdata)
    );

    wgt_tile_bank #(
        .ARRAY_N (ARRAY_N),
        .ROW_W   (ROW_BITS),
        .AW      (AW)
    ) u_bank1 (
        .clk     (clk),
        .we_i    (wr_en && wr_sel_q),
        .waddr_i (wr_addr),
        .wdata_i (rd_data),
        .raddr_i (rd_addr),
        .rdata_o (bank1_rdata)
    );

    assign wr_addr     = wr_row_q[AW-1:0];
    // Read address looks one row ahead so the registered output shows row rd_row_q+1 next cycle.
    assign rd_addr     = (state_q == SHIFT) ? AW'(rd_row_q + 1'b1) : '0;
    assign rd_row_data = rd_sel_q ? bank1_rdata : bank0_rdata;

    always_comb begin
        wr_row_d = wr_row_q;
        wr_sel_d = wr_sel_q;
        ovf_d    = ovf_q;
        full_set = '0;
        wr_en    = 1'b0;
        if (rd_vld) begin
            if (!full_q[wr_sel_q]) begin
                wr_en = 1'b1;
                if (wr_row_q == LAST_ROW) begin
                    full_set[wr_sel_q] = 1'b1;
                    wr_sel_d           = ~wr_sel_q;
                    wr_row_d           = '0;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_row_d     = rd_row_q;
        rd_sel_d     = rd_sel_q;
        shift_en_d   = 1'b0;
        shift_data_d = '0;
        swap_d       = 1'b0;
        full_clr     = '0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_sel_q] && array_wgt_req) begin
                    state_d      = SHIFT;
                    rd_row_d     = '0;
                    shift_en_d   = 1'b1;
                    shift_data_d = rd_row_data;
                end
            end
            SHIFT: begin
                if (rd_row_q == LAST_ROW) begin
                    state_d = SWAP;
                    swap_d  = 1'b1;
                end else begin
                    rd_row_d     = rd_row_q + 1'b1;
                    shift_en_d   = 1'b1;
                    shift_data_d = rd_row_data;
                end
            end
            SWAP: begin
                full_clr[rd_sel_q] = 1'b1;
                rd_sel_d           = ~rd_sel_q;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Set and clear always address different banks; overflow uses the pre-update flags.
    always_comb begin
        full_d = (full_q | full_set) & ~full_clr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dly_q        <= '0;
            wr_row_q     <= '0;
            wr_sel_q     <= 1'b0;
            full_q       <= '0;
            ovf_q        <= 1'b0;
            state_q      <= IDLE;
            rd_row_q     <= '0;
            rd_sel_q     <= 1'b0;
            shift_en_q   <= 1'b0;
            shift_data_q <= '0;
            swap_q       <= 1'b0;
        end else begin
            dly_q[0] <= rd_req;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            wr_row_q     <= wr_row_d;
            wr_sel_q     <= wr_sel_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            rd_row_q     <= rd_row_d;
            rd_sel_q     <= rd_sel_d;
            shift_en_q   <= shift_en_d;
            shift_data_q <= shift_data_d;
            swap_q       <= swap_d;
        end
    end

    assign wgt_ready      = ~full_q[wr_sel_q];
    assign wgt_shift_en   = shift_en_q;
    assign wgt_shift_data = shift_data_q;
    assign wgt_swap       = swap_q;
    assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_wgt_tile_loader.sv
// Self-checking bench for wgt_tile_loader: directed scenarios plus randomized tiles
// against a queue-based model of expected shifted rows.
module tb_wgt_tile_loader;

    localparam int unsigned N      = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RW     = N * DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [RW-1:0] rd_data;
    logic          wgt_ready;
    logic          array_wgt_req = 1'b0;
    logic          wgt_shift_en;
    logic [RW-1:0] wgt_shift_data;
    logic          wgt_swap;
    logic          ovf_err;

    wgt_tile_loader #(
        .ARRAY_N (N),
        .DATA_W  (DW),
        .RD_LAT  (RD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .wgt_ready      (wgt_ready),
        .array_wgt_req  (array_wgt_req),
        .wgt_shift_en   (wgt_shift_en),
        .wgt_shift_data (wgt_shift_data),
        .wgt_swap       (wgt_swap),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: the row requested in one cycle appears on rd_data RD_LAT cycles later.
    logic [RW-1:0] req_row = '0;
    logic [RW-1:0] dpipe [RD_LAT];
    always @(posedge clk) begin
        dpipe[0] <= req_row;
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign rd_data = dpipe[RD_LAT-1];

    int unsigned n_err = 0;
    int unsigned n_chk = 0;

    task automatic check_eq(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: rows the array must receive, in order; tiles dropped on overflow are never queued.
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] tile [N];

    int unsigned shift_run = 0;
    int unsigned run_start_cyc = 0;
    int unsigned last_swap = 0;
    bit          have_swap = 0;
    bit          swap_prev = 0;
    int unsigned swap_cyc_q [$];
    bit          rdy_swap_q [$];
    bit          rdy_after_q [$];

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            shift_run = 0;
            have_swap = 0;
            swap_prev = 0;
            exp_q.delete();
        end else begin
            if (swap_prev) rdy_after_q.push_back(wgt_ready);
            swap_prev = wgt_swap;
            if (wgt_swap) begin
                check_eq("swap_after_rows", RW'(shift_run), RW'(N));
                check_eq("swap_no_shift", RW'(wgt_shift_en), '0);
                if (have_swap) check_eq("swap_spacing_min", RW'((cyc - last_swap) >= N + 2), RW'(1));
                have_swap = 1;
                last_swap = cyc;
                swap_cyc_q.push_back(cyc);
                rdy_swap_q.push_back(wgt_ready);
                shift_run = 0;
            end else if (wgt_shift_en) begin
                if (shift_run == 0) run_start_cyc = cyc;
                shift_run++;
                if (exp_q.size() == 0) check_eq("unexpected_shift", RW'(wgt_shift_en), '0);
                else check_eq("shift_row", wgt_shift_data, exp_q.pop_front());
            end else if (shift_run != 0) begin
                check_eq("swap_after_rows", RW'(wgt_swap), RW'(1));
                shift_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int j = 0; j < int'(RW / 32); j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic make_tile(input bit random, input int unsigned base);
        for (int i = 0; i < N; i++) begin
            if (random) tile[i] = rand_row();
            else tile[i] = {N{8'(base + i)}};
        end
    endtask

    int unsigned last_req_cyc = 0;

    task automatic load_tile(input bit accept, input bit gaps, input bit rand_req);
        if (accept) for (int i = 0; i < N; i++) exp_q.push_back(tile[i]);
        for (int i = 0; i < N; i++) begin
            int unsigned g;
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                rd_req  = 1'b0;
                req_row = rand_row();
                if (rand_req) array_wgt_req = ($urandom_range(0, 3) != 0);
                tick();
            end
            rd_req  = 1'b1;
            req_row = tile[i];
            if (rand_req) array_wgt_req = ($urandom_range(0, 3) != 0);
            last_req_cyc = cyc;
            tick();
        end
        rd_req  = 1'b0;
        req_row = rand_row();
    endtask

    task automatic flush();
        rd_req = 1'b0;
        repeat (RD_LAT + 2) tick();
    endtask

    task automatic wait_ready(input bit rand_req);
        for (int i = 0; i < 400 && !wgt_ready; i++) begin
            if (rand_req) array_wgt_req = ($urandom_range(0, 3) != 0);
            tick();
        end
        check_eq("ready_wait", RW'(wgt_ready), RW'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 800 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        check_eq("drain_empty", RW'(exp_q.size()), '0);
    endtask

    task automatic apply_reset();
        reset_n       = 1'b0;
        rd_req        = 1'b0;
        array_wgt_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s1_last;

        tick();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_eq("rst_shift_en", RW'(wgt_shift_en), '0);
        check_eq("rst_shift_data", wgt_shift_data, '0);
        check_eq("rst_swap", RW'(wgt_swap), '0);
        check_eq("rst_ready", RW'(wgt_ready), RW'(1));
        check_eq("rst_ovf", RW'(ovf_err), '0);

        // One tile straight through, array always requesting.
        array_wgt_req = 1'b1;
        swap_cyc_q.delete();
        make_tile(1'b0, 0);
        load_tile(1'b1, 1'b0, 1'b0);
        s1_last = last_req_cyc;
        wait_drain();
        check_eq("s1_shift_latency", RW'(run_start_cyc - s1_last), RW'(RD_LAT + 2));
        check_eq("s1_swap_count", RW'(swap_cyc_q.size()), RW'(1));
        check_eq("s1_ready", RW'(wgt_ready), RW'(1));

        // Two tiles buffered while the array is busy, then drained back to back.
        array_wgt_req = 1'b0;
        swap_cyc_q.delete();
        rdy_swap_q.delete();
        rdy_after_q.delete();
        make_tile(1'b0, 16);
        load_tile(1'b1, 1'b0, 1'b0);
        flush();
        check_eq("s2_ready_one_full", RW'(wgt_ready), RW'(1));
        make_tile(1'b0, 48);
        load_tile(1'b1, 1'b0, 1'b0);
        flush();
        check_eq("s2_ready_both_full", RW'(wgt_ready), '0);
        check_eq("s2_no_drain_without_req", RW'(wgt_shift_en), '0);
        array_wgt_req = 1'b1;
        wait_drain();
        check_eq("s2_swap_count", RW'(swap_cyc_q.size()), RW'(2));
        if (swap_cyc_q.size() >= 2) check_eq("s2_swap_gap", RW'(swap_cyc_q[1] - swap_cyc_q[0]), RW'(N + 2));
        if (rdy_swap_q.size() >= 1) check_eq("s2_ready_at_swap", RW'(rdy_swap_q[0]), '0);
        if (rdy_after_q.size() >= 1) check_eq("s2_ready_after_swap", RW'(rdy_after_q[0]), RW'(1));

        // Third tile arrives with both banks full: its rows are dropped.
        array_wgt_req = 1'b0;
        check_eq("s3_ovf_before", RW'(ovf_err), '0);
        make_tile(1'b0, 80);
        load_tile(1'b1, 1'b0, 1'b0);
        flush();
        make_tile(1'b0, 112);
        load_tile(1'b1, 1'b0, 1'b0);
        flush();
        make_tile(1'b1, 0);
        load_tile(1'b0, 1'b0, 1'b0);
        flush();
        check_eq("s3_ready", RW'(wgt_ready), '0);
        check_eq("s3_ovf_set", RW'(ovf_err), RW'(1));
        array_wgt_req = 1'b1;
        wait_drain();
        check_eq("s3_ovf_sticky", RW'(ovf_err), RW'(1));
        check_eq("s3_ready_after", RW'(wgt_ready), RW'(1));
        apply_reset();
        check_eq("s3_ovf_cleared", RW'(ovf_err), '0);

        // Fill the second bank while the first is shifting out.
        array_wgt_req = 1'b1;
        make_tile(1'b1, 0);
        load_tile(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100 && !wgt_shift_en; i++) tick();
        check_eq("s4_shift_started", RW'(wgt_shift_en), RW'(1));
        check_eq("s4_ready_during_shift", RW'(wgt_ready), RW'(1));
        make_tile(1'b1, 0);
        load_tile(1'b1, 1'b1, 1'b0);
        wait_drain();

        // Reset while row 7 is on the shift chain, then reload from scratch.
        make_tile(1'b1, 0);
        load_tile(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && shift_run != 7; i++) tick();
        check_eq("s5_at_row7", RW'(shift_run), RW'(7));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("s5_shift_en", RW'(wgt_shift_en), '0);
        check_eq("s5_swap", RW'(wgt_swap), '0);
        check_eq("s5_ready", RW'(wgt_ready), RW'(1));
        check_eq("s5_ovf", RW'(ovf_err), '0);
        tick();
        make_tile(1'b0, 200);
        load_tile(1'b1, 1'b0, 1'b0);
        wait_drain();

        // Randomized tiles, gaps and array request pattern.
        for (int t = 0; t < 6; t++) begin
            wait_ready(1'b1);
            make_tile(1'b1, 0);
            load_tile(1'b1, 1'b1, 1'b1);
            flush();
        end
        array_wgt_req = 1'b1;
        wait_drain();
        check_eq("final_no_ovf", RW'(ovf_err), '0);
        check_eq("final_ready", RW'(wgt_ready), RW'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
